pulse_trigger_receiver_mc: RTL and testbench



---
 rtl/pulse_trigger_receiver_mc.sv | 187 ++++++++++++++++++
 tb/tb_pulse_trigger_receiver_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_trigger_receiver_mc.sv
// Multi-channel front-panel pulse trigger receiver: forwards a one-cycle channel trigger,
// classifies the trigger level over a sampling window and guards per-channel DDR3 occupancy.
// Optional macro TRIG_EDGE_EN makes IDLE accept only rising edges of the trigger.
module pulse_trigger_receiver_mc #(
    parameter int NUM_CHAN = 5,
    parameter int BURST_W  = 23,
    parameter int CAPACITY = 524288,
    parameter int WIN_LEN  = 4,
    parameter int NUM_W    = 24,
    parameter int TS_W     = 44
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_trig_num,
    input  logic                         reset_trig_timestamp,
    input  logic                         trigger,
    input  logic [NUM_CHAN-1:0]          chan_en,
    input  logic [NUM_CHAN*BURST_W-1:0]  burst_count,
    input  logic [BURST_W-1:0]           thres_overflow,
    input  logic                         readout_done,
    input  logic                         fifo_ready,
    output logic                         fifo_valid,
    output logic [127:0]                 fifo_data,
    output logic                         pulse_trigger,
    output logic [NUM_W-1:0]             trig_num,
    output logic [4:0]                   state,
    output logic [31:0]                  overflow_count,
    output logic                         overflow_warning
);

    localparam logic [4:0] S_IDLE     = 5'b00001;
    localparam logic [4:0] S_SEND     = 5'b00010;
    localparam logic [4:0] S_SAMPLE   = 5'b00100;
    localparam logic [4:0] S_CLASSIFY = 5'b01000;
    localparam logic [4:0] S_STORE    = 5'b10000;

    localparam int IDX_W = $clog2(WIN_LEN);
    localparam int PAD_W = 128 - NUM_W - TS_W - 2;
    localparam logic [BURST_W:0] CAP_EXT = (BURST_W+1)'(CAPACITY);

    logic [4:0]         state_reg;
    logic [NUM_W-1:0]   trig_num_reg;
    logic [TS_W-1:0]    ts_cnt_reg;
    logic [TS_W-1:0]    ts_latch_reg;
    logic [31:0]        overflow_count_reg;
    logic [WIN_LEN-1:0] history_reg;
    logic [IDX_W-1:0]   sample_idx_reg;
    logic               pulse_reg;
    logic               fifo_valid_reg;
    logic [127:0]       fifo_data_reg;
    logic               trig_prev_reg;

    logic [NUM_CHAN-1:0] chan_full;
    logic [NUM_CHAN-1:0] chan_warn;
    logic                full;
    logic                trig_hit;
    logic                accept;
    logic                reject;
    logic                in_send;
    logic [1:0]          trig_length;

`ifdef TRIG_EDGE_EN
    assign trig_hit = trigger && !trig_prev_reg;
`else
    assign trig_hit = trigger;
`endif

    assign full    = |chan_full;
    assign in_send = (state_reg == S_SEND);
    assign accept  = (state_reg == S_IDLE) && trig_hit && !full;
    assign reject  = (state_reg == S_IDLE) && trig_hit && full;

    // Room check is done one bit wider so CAPACITY minus occupancy never wraps against burst+1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            logic [BURST_W-1:0] occ_reg;
            logic [BURST_W:0]   burst_plus;
            logic [BURST_W:0]   room;

            assign burst_plus    = {1'b0, burst_count[gi*BURST_W +: BURST_W]} + (BURST_W+1)'(1);
            assign room          = CAP_EXT - {1'b0, occ_reg};
            assign chan_full[gi] = chan_en[gi] && (room < burst_plus);
            assign chan_warn[gi] = occ_reg > thres_overflow;

            always_ff @(posedge clk) begin
                if (reset) begin
                    occ_reg <= '0;
                end else if (in_send && chan_en[gi]) begin
                    occ_reg <= (readout_done ? '0 : occ_reg) + burst_plus[BURST_W-1:0];
                end else if (readout_done) begin
                    occ_reg <= '0;
                end
            end
        end
    endgenerate

    assign overflow_warning = |chan_warn;

    // history_reg shifts the samples in above the accept bit; all-ones means held high throughout.
    always_comb begin
        trig_length = 2'b11;
        if (!trigger) begin
            trig_length = 2'b10;
        end else if (&history_reg) begin
            trig_length = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            trig_num_reg       <= '0;
            ts_cnt_reg         <= '0;
            ts_latch_reg       <= '0;
            overflow_count_reg <= '0;
            history_reg        <= '0;
            sample_idx_reg     <= '0;
            pulse_reg          <= 1'b0;
            fifo_valid_reg     <= 1'b0;
            fifo_data_reg      <= '0;
            trig_prev_reg      <= 1'b0;
        end else begin
            trig_prev_reg <= trigger;
            pulse_reg     <= accept;
            ts_cnt_reg    <= reset_trig_timestamp ? '0 : ts_cnt_reg + TS_W'(1);

            if (reset_trig_num || readout_done) begin
                trig_num_reg <= '0;
            end else if (accept) begin
                trig_num_reg <= trig_num_reg + NUM_W'(1);
            end

            if (reset_trig_timestamp) begin
                ts_latch_reg <= '0;
            end else if (accept) begin
                ts_latch_reg <= ts_cnt_reg;
            end

            if (reject && (overflow_count_reg != 32'hFFFF_FFFF)) begin
                overflow_count_reg <= overflow_count_reg + 32'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        history_reg <= WIN_LEN'(1);
                        state_reg   <= S_SEND;
                    end
                end
                S_SEND: begin
                    history_reg    <= {history_reg[WIN_LEN-2:0], trigger};
                    sample_idx_reg <= IDX_W'(2);
                    state_reg      <= (WIN_LEN > 2) ? S_SAMPLE : S_CLASSIFY;
                end
                S_SAMPLE: begin
                    history_reg    <= {history_reg[WIN_LEN-2:0], trigger};
                    sample_idx_reg <= sample_idx_reg + IDX_W'(1);
                    if (sample_idx_reg == IDX_W'(WIN_LEN-1)) begin
                        state_reg <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    fifo_data_reg  <= {{PAD_W{1'b0}}, trig_length, trig_num_reg, ts_latch_reg};
                    fifo_valid_reg <= 1'b1;
                    state_reg      <= S_STORE;
                end
                S_STORE: begin
                    if (fifo_ready) begin
                        fifo_valid_reg <= 1'b0;
                        history_reg    <= '0;
                        state_reg      <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign state          = state_reg;
    assign trig_num       = trig_num_reg;
    assign overflow_count = overflow_count_reg;
    assign pulse_trigger  = pulse_reg;
    assign fifo_valid     = fifo_valid_reg;
    assign fifo_data      = fifo_data_reg;

endmodule

// File: tb/tb_pulse_trigger_receiver_mc.sv
// Scoreboard bench for pulse_trigger_receiver_mc: directed stimulus pushes expected FIFO words,
// an independent monitor pops and compares them on each accepted handshake.
module tb_pulse_trigger_receiver_mc;
    localparam int NUM_CHAN = 5;
    localparam int BURST_W  = 23;
    localparam int NUM_W    = 24;
    localparam int TS_W     = 44;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        reset_trig_num;
    logic                        reset_trig_timestamp;
    logic                        trigger;
    logic [NUM_CHAN-1:0]         chan_en;
    logic [NUM_CHAN*BURST_W-1:0] burst_count;
    logic [BURST_W-1:0]          thres_overflow;
    logic                        readout_done;
    logic                        fifo_ready;
    logic                        fifo_valid;
    logic [127:0]                fifo_data;
    logic                        pulse_trigger;
    logic [NUM_W-1:0]            trig_num;
    logic [4:0]                  state;
    logic [31:0]                 overflow_count;
    logic                        overflow_warning;

    pulse_trigger_receiver_mc #(.CAPACITY(16)) dut (
        .clk(clk), .reset(reset), .reset_trig_num(reset_trig_num),
        .reset_trig_timestamp(reset_trig_timestamp), .trigger(trigger), .chan_en(chan_en),
        .burst_count(burst_count), .thres_overflow(thres_overflow), .readout_done(readout_done),
        .fifo_ready(fifo_ready), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .pulse_trigger(pulse_trigger), .trig_num(trig_num), .state(state),
        .overflow_count(overflow_count), .overflow_warning(overflow_warning)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    logic [127:0] sb[$];
    logic [TS_W-1:0] tb_ts;
    int exp_num = 0;

    // Reference free-running timestamp, cleared by the same controls as the device.
    always_ff @(posedge clk) begin
        if (reset || reset_trig_timestamp) tb_ts <= '0;
        else tb_ts <= tb_ts + TS_W'(1);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [1:0] len, input int num, input logic [TS_W-1:0] ts);
        logic [NUM_W-1:0] n;
        n = NUM_W'(num);
        return {58'b0, len, n, ts};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every handshake, and checks the word is held while stalled.
    initial begin
        logic [127:0] hold_data;
        logic hold_valid;
        logic [127:0] exp;
        hold_valid = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_valid = 1'b0;
            end else begin
                if (fifo_valid && hold_valid) check("stall_stable", fifo_data, hold_data);
                hold_valid = fifo_valid && !fifo_ready;
                hold_data = fifo_data;
                if (fifo_valid && fifo_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", fifo_data, 128'h0);
                    end else begin
                        exp = sb.pop_front();
                        check("fifo_word", fifo_data, exp);
                        $display("[TB] word len=%b num=%0d ts=%0d", fifo_data[69:68],
                                 fifo_data[67:44], fifo_data[43:0]);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat[6];
        logic [4:0] exp_state;
        reset = 1'b1; reset_trig_num = 1'b0; reset_trig_timestamp = 1'b0; trigger = 1'b0;
        chan_en = '0; burst_count = '0; thres_overflow = 23'd7; readout_done = 1'b0; fifo_ready = 1'b1;
        repeat (3) tick();
        check("rst_state", state, 5'b00001);
        check("rst_valid", fifo_valid, 1'b0);
        check("rst_data", fifo_data, 128'h0);
        check("rst_pulse", pulse_trigger, 1'b0);
        check("rst_num", trig_num, 0);
        check("rst_ovf", overflow_count, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single-cycle trigger: laser classification
        trigger = 1'b1; exp_num++; sb.push_back(mk(2'b10, exp_num, tb_ts));
        tick();
        trigger = 1'b0;
        check("t1_pulse", pulse_trigger, 1'b1);
        check("t1_state_send", state, 5'b00010);
        check("t1_num", trig_num, exp_num);
        tick();
        check("t1_pulse_off", pulse_trigger, 1'b0);
        check("t1_state_sample", state, 5'b00100);
        repeat (3) tick();
        check("t1_valid_t5", fifo_valid, 1'b1);
        check("t1_state_store", state, 5'b10000);
        repeat (2) tick();

        // Held-high trigger: Am classification, then re-accept in level mode only
        for (int i = 0; i < 16; i++) begin
            trigger = (i < 8);
            if (i == 0) begin exp_num++; sb.push_back(mk(2'b01, exp_num, tb_ts)); end
`ifndef TRIG_EDGE_EN
            if (i == 6) begin exp_num++; sb.push_back(mk(2'b10, exp_num, tb_ts)); end
            exp_state = 5'b00010;
`else
            exp_state = 5'b00001;
`endif
            if (i == 6) check("t2_idle_t6", state, 5'b00001);
            if (i == 7) check("t2_state_t7", state, exp_state);
            tick();
        end
        check("t2_num", trig_num, exp_num);

        // Timestamp clear, then pattern 1,0,0,1,1: laser+Am
        reset_trig_timestamp = 1'b1; tick();
        reset_trig_timestamp = 1'b0; tick();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            trigger = (i < 6) ? pat[i] : 1'b0;
            if (i == 0) begin exp_num++; sb.push_back(mk(2'b11, exp_num, tb_ts)); end
            tick();
        end

        // Back-pressure: 10 stalled cycles in STORE with ignored triggers
        for (int i = 0; i < 18; i++) begin
            trigger = (i == 0) || (i >= 6 && i <= 12 && (i % 2 == 1));
            fifo_ready = (i >= 15);
            if (i == 0) begin exp_num++; sb.push_back(mk(2'b10, exp_num, tb_ts)); end
            if (i == 14) begin
                check("t4_state_store", state, 5'b10000);
                check("t4_valid", fifo_valid, 1'b1);
                check("t4_num_held", trig_num, exp_num);
                check("t4_ovf", overflow_count, 0);
            end
            tick();
        end
        trigger = 1'b0; fifo_ready = 1'b1;
        tick();

        // Occupancy: capacity 16, burst 4 per trigger on channel 0
        chan_en = 5'b00001;
        for (int c = 1; c < NUM_CHAN; c++) burst_count[c*BURST_W +: BURST_W] = 23'd100;
        burst_count[0 +: BURST_W] = 23'd3;
        readout_done = 1'b1; tick(); readout_done = 1'b0;
        exp_num = 0;
        check("t5_num_clr", trig_num, 0);
        for (int k = 1; k <= 4; k++) begin
            trigger = 1'b1; exp_num++; sb.push_back(mk(2'b10, exp_num, tb_ts));
            tick();
            trigger = 1'b0;
            check("t5_accept", state, 5'b00010);
            repeat (7) tick();
            check("t5_warn", overflow_warning, (k >= 2));
        end
        check("t5_ovf0", overflow_count, 0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        check("t5_reject_state", state, 5'b00001);
        check("t5_reject_pulse", pulse_trigger, 1'b0);
        check("t5_ovf1", overflow_count, 1);
        check("t5_num4", trig_num, 4);
        tick();
        readout_done = 1'b1; tick(); readout_done = 1'b0;
        check("t5_readout_num", trig_num, 0);
        check("t5_readout_warn", overflow_warning, 1'b0);
        exp_num = 1;
        trigger = 1'b1; sb.push_back(mk(2'b10, exp_num, tb_ts));
        tick(); trigger = 1'b0;
        check("t5_after_readout", state, 5'b00010);
        repeat (7) tick();
        check("t5_warn_low", overflow_warning, 1'b0);

        // Reset in SAMPLE aborts the trigger
        trigger = 1'b1; tick(); trigger = 1'b0;
        tick();
        check("t6_sample", state, 5'b00100);
        check("t6_num_pre", trig_num, 2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_state", state, 5'b00001);
        check("t6_valid", fifo_valid, 1'b0);
        check("t6_num", trig_num, 0);
        check("t6_ovf", overflow_count, 0);
        check("t6_pulse", pulse_trigger, 1'b0);
        repeat (10) tick();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
